// File: rtl/store_rmw_if.sv
// Store-side interface for store_rmw: the core request plus the word-wide memory port.
// The slave modport is the RMW engine; the master modport is the core and memory side.
interface store_rmw_if;
  logic        req;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd;
  logic [31:0] mem_wd;
  logic        mem_we;

  modport slave (
    input  req, funct3, addr, wdata, mem_rd,
    output busy, done, err, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req, funct3, addr, wdata, mem_rd,
    input  busy, done, err, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/store_rmw.sv
// Byte/halfword/word store engine over a word-only memory: sub-word stores read the
// containing word, splice in the new lane and write it back.
module store_rmw (
  input  logic         clk,
  input  logic         rst,
  store_rmw_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_e;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] merge_q, merge_d;
  logic        errf_q, errf_d;

  logic        busy_q, done_q, err_q, we_q;
  logic        bad_req;
  logic [31:0] lane_word;

  // Misaligned or unknown-width stores are rejected at acceptance time.
  always_comb begin
    bad_req = 1'b0;
    case (bus.funct3)
      F3_SB:   bad_req = 1'b0;
      F3_SH:   bad_req = bus.addr[0];
      F3_SW:   bad_req = (bus.addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
  end

  // Little-endian lane splice; bits outside the lane pass through from memory.
  always_comb begin
    lane_word = bus.mem_rd;
    if (f3_q == F3_SB) begin
      case (addr_q[1:0])
        2'd0:    lane_word[7:0]   = wd_q[7:0];
        2'd1:    lane_word[15:8]  = wd_q[7:0];
        2'd2:    lane_word[23:16] = wd_q[7:0];
        default: lane_word[31:24] = wd_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) lane_word[31:16] = wd_q[15:0];
      else           lane_word[15:0]  = wd_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wd_d    = wd_q;
    merge_d = merge_q;
    errf_d  = errf_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d = bus.addr;
          f3_d   = bus.funct3;
          wd_d   = bus.wdata;
          errf_d = bad_req;
          if (bad_req)                  state_d = DONE;
          else if (bus.funct3 == F3_SW) state_d = WRITE;
          else                          state_d = READ;
        end
      end
      READ:  state_d = MERGE;
      MERGE: begin
        merge_d = lane_word;
        state_d = WRITE;
      end
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they change only with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      merge_q <= '0;
      errf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wd_q    <= wd_d;
      merge_q <= merge_d;
      errf_q  <= errf_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == DONE) && errf_d;
      we_q    <= (state_d == WRITE);
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = {addr_q[31:2], 2'b00};
  assign bus.mem_wd   = (f3_q == F3_SW) ? wd_q : merge_q;

endmodule

// File: doc/store_rmw.md
STORE_RMW -- requirements
Module: store_rmw

Interface
REQ-001 Parameters: none; all data and address paths are 32 bits.
REQ-002 clk  in  1  core clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 req  in  1  store request; sampled only in IDLE.
REQ-005 funct3  in  3  store width: 3'b000 sb, 3'b001 sh, 3'b010 sw; all other codes are illegal.
REQ-006 addr  in  32  byte address of the store.
REQ-007 wdata  in  32  store source value (rs2); only the low byte or halfword is used for sb/sh.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse on completion.
REQ-010 err  out  1  one-cycle pulse coincident with done for a misaligned or illegal store.
REQ-011 mem_addr  out  32  word address {addr_q[31:2], 2'b00}.
REQ-012 mem_rd  in  32  memory read data, valid one cycle after mem_addr is presented with mem_we=0.
REQ-013 mem_wd  out  32  memory write data.
REQ-014 mem_we  out  1  memory write enable; full-word write, no byte enables.

Function
REQ-015 FSM states: IDLE, READ, MERGE, WRITE, DONE; all outputs decoded from state and registers (Moore).
REQ-016 In IDLE with req=1: latch addr, funct3 and wdata into addr_q/f3_q/wd_q; the next state is selected by the rules below.
REQ-017 In IDLE, req=0 keeps the FSM in IDLE.
REQ-018 Next state is DONE with err set for any of: illegal funct3, sh with addr[0]=1, sw with addr[1:0]!=0.
REQ-019 Next state is WRITE for an aligned sw; next state is READ for sb and for an aligned sh.
REQ-020 READ: mem_addr is driven, mem_we=0; the next state is MERGE.
REQ-021 MERGE: capture mem_rd into merge_q with the selected lane replaced; the next state is WRITE.
REQ-022 sb lane (little-endian): addr_q[1:0] selects the byte; 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]; the lane takes wd_q[7:0].
REQ-023 sh lane: addr_q[1]=0 -> [15:0], addr_q[1]=1 -> [31:16]; the lane takes wd_q[15:0].
REQ-024 Non-selected bits of merge_q equal mem_rd exactly; no sign or zero extension.
REQ-025 WRITE: mem_we=1 for exactly one cycle; mem_wd = wd_q for sw, merge_q for sb/sh; the next state is DONE.
REQ-026 DONE: done=1, err=1 if the error was flagged; mem_we=0; the next state is IDLE unconditionally.
REQ-027 Latency from the req-sampling edge to done high: sw 2 cycles, sb/sh 4 cycles, error 1 cycle.
REQ-028 req while busy=1 is ignored and not queued; the latched operands are not modified.
REQ-029 Back-to-back: req high in the cycle after DONE (state IDLE) is accepted.
REQ-030 mem_we is never asserted for an error request; memory is left unmodified.
REQ-031 mem_wd and mem_addr are don't-care whenever mem_we=0, except that mem_addr is valid in READ.

Reset
REQ-032 rst=1 at a clock edge forces state IDLE and clears addr_q, f3_q, wd_q, merge_q and the error flag to 0.
REQ-033 Output values after reset: busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wd=0.
REQ-034 Reset in any state, including WRITE, aborts the operation: no done pulse follows, and mem_we=0 from the reset edge onward.
REQ-035 Reset has priority over req in the same cycle.

Verification
REQ-036 Memory word 0xdeadbeef at 0x108; sb wdata=0x00000012, addr=0x109 -> one write to 0x108 of 0xdead12ef; done 4 cycles after req; err=0.
REQ-037 Same initial word; sh wdata=0xffffc0de, addr=0x10a -> write of 0xc0debeef; then sb wdata=0x000000aa, addr=0x10b -> word 0xaadebeef.
REQ-038 sw wdata=0xc001c0de, addr=0x108 -> no READ state entered; write of 0xc001c0de 1 cycle after req; done 2 cycles after req.
REQ-039 sh addr=0x10b, sw addr=0x10a, and funct3=3'b011 -> done and err both high 1 cycle after req; mem_we never high; word unchanged.
REQ-040 Reset pulse while in MERGE during an sb -> mem_we stays 0; no done pulse; busy=0 after the reset edge; memory unchanged.
REQ-041 Second req (sw, 0x0000ffff) asserted while the first sb is in READ -> ignored; exactly one write, carrying the sb result.
